vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 24 ++
 rtl/change_dispenser.sv | 35 +++
 rtl/vend_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending controller
package vend_pkg;

    localparam int CREDIT_W = 8;

    localparam logic [CREDIT_W-1:0] PRICE2 = 8'd2;
    localparam logic [CREDIT_W-1:0] PRICE6 = 8'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    // A selection is honoured only when both credit and stock cover it.
    function automatic logic can_afford(
        input logic [CREDIT_W-1:0] cr,
        input logic [CREDIT_W-1:0] price,
        input logic [3:0]          stock
    );
        return (cr >= price) && (stock != 4'd0);
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - refund counter emitting one high/low pulse pair per unit
module change_dispenser
    import vend_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    output logic                pulse,
    output logic                done
);

    logic [CREDIT_W-1:0] r_cnt;
    logic                r_pulse;

    // r_cnt counts units still owed, including the one whose high cycle is showing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (load) begin
            r_cnt   <= load_val;
            r_pulse <= (load_val != '0);
        end else if (r_pulse) begin
            r_pulse <= 1'b0;
            r_cnt   <= r_cnt - 8'd1;
        end else if (r_cnt != '0) begin
            r_pulse <= 1'b1;
        end
    end

    assign pulse = r_pulse;
    assign done  = (r_cnt == '0) && !r_pulse;

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - two-product coin vending controller with credit, stock and refund
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int STOCK_INIT  = 8,
    parameter int VEND_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          coin,
    input  logic                sel2,
    input  logic                sel6,
    input  logic                cancel,
    input  logic                restock,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend2,
    output logic                vend6,
    output logic                deny,
    output logic                coin_rej,
    output logic                change_pulse,
    output logic                busy,
    output logic                empty2,
    output logic                empty6
);

    localparam logic [3:0] STOCK_FULL = 4'(STOCK_INIT);
    localparam logic [2:0] VEND_LAST  = 3'(VEND_CYCLES - 1);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [3:0]          r_stock2;
    logic [3:0]          r_stock6;
    logic [2:0]          r_vcnt;
    logic                r_vend2;
    logic                r_vend6;
    logic                r_deny;
    logic                r_coin_rej;
    logic                r_busy;
    logic                r_empty2;
    logic                r_empty6;

    logic                w_idle;
    logic                w_coin;
    logic [CREDIT_W:0]   w_sum;
    logic                w_cancel_ok;
    logic                w_sel6_req;
    logic                w_sel6_ok;
    logic                w_sel2_req;
    logic                w_sel2_ok;
    logic                w_restock;
    logic                w_take;
    logic                w_coin_add;
    logic                w_chg_pulse;
    logic                w_chg_done;

    // An asserted cancel claims the cycle even with zero credit, masking selections.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_coin      = (coin != 4'd0);
    assign w_sum       = {1'b0, r_credit} + {5'd0, coin};
    assign w_cancel_ok = w_idle && cancel && (r_credit != '0);
    assign w_sel6_req  = w_idle && !cancel && sel6;
    assign w_sel6_ok   = w_sel6_req && can_afford(r_credit, PRICE6, r_stock6);
    assign w_sel2_req  = w_idle && !cancel && !sel6 && sel2;
    assign w_sel2_ok   = w_sel2_req && can_afford(r_credit, PRICE2, r_stock2);
    assign w_restock   = w_idle && !cancel && !sel6 && !sel2 && restock;
    assign w_take      = w_cancel_ok || w_sel6_ok || w_sel2_ok;
    assign w_coin_add  = w_idle && w_coin && !w_take && !w_sum[CREDIT_W];

    change_dispenser u_change (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cancel_ok),
        .load_val (r_credit),
        .pulse    (w_chg_pulse),
        .done     (w_chg_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_stock2   <= STOCK_FULL;
            r_stock6   <= STOCK_FULL;
            r_vcnt     <= '0;
            r_vend2    <= 1'b0;
            r_vend6    <= 1'b0;
            r_deny     <= 1'b0;
            r_coin_rej <= 1'b0;
            r_busy     <= 1'b0;
            r_empty2   <= 1'b0;
            r_empty6   <= 1'b0;
        end else begin
            r_deny     <= 1'b0;
            r_coin_rej <= w_coin && !w_coin_add;
            if (w_coin_add) begin
                r_credit <= w_sum[CREDIT_W-1:0];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cancel_ok) begin
                        r_credit <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CHANGE;
                    end else if (w_sel6_req) begin
                        if (w_sel6_ok) begin
                            r_credit <= r_credit - PRICE6;
                            r_stock6 <= r_stock6 - 4'd1;
                            r_empty6 <= (r_stock6 == 4'd1);
                            r_vend6  <= 1'b1;
                            r_vcnt   <= VEND_LAST;
                            r_busy   <= 1'b1;
                            r_state  <= ST_VEND;
                        end else begin
                            r_deny <= 1'b1;
                        end
                    end else if (w_sel2_req) begin
                        if (w_sel2_ok) begin
                            r_credit <= r_credit - PRICE2;
                            r_stock2 <= r_stock2 - 4'd1;
                            r_empty2 <= (r_stock2 == 4'd1);
                            r_vend2  <= 1'b1;
                            r_vcnt   <= VEND_LAST;
                            r_busy   <= 1'b1;
                            r_state  <= ST_VEND;
                        end else begin
                            r_deny <= 1'b1;
                        end
                    end else if (w_restock) begin
                        r_stock2 <= STOCK_FULL;
                        r_stock6 <= STOCK_FULL;
                        r_empty2 <= 1'b0;
                        r_empty6 <= 1'b0;
                    end
                end
                ST_VEND: begin
                    if (r_vcnt == 3'd0) begin
                        r_vend2 <= 1'b0;
                        r_vend6 <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_vcnt <= r_vcnt - 3'd1;
                    end
                end
                ST_CHANGE: begin
                    if (w_chg_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_vend2 <= 1'b0;
                    r_vend6 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign credit       = r_credit;
    assign vend2        = r_vend2;
    assign vend6        = r_vend6;
    assign deny         = r_deny;
    assign coin_rej     = r_coin_rej;
    assign change_pulse = w_chg_pulse;
    assign busy         = r_busy;
    assign empty2       = r_empty2;
    assign empty6       = r_empty6;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl against a transaction-level model
module tb_vend_ctrl;

    localparam int SI = 2;
    localparam int VC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] coin;
    logic       sel2, sel6, cancel, restock;
    logic [7:0] credit;
    logic       vend2, vend6, deny, coin_rej, change_pulse, busy, empty2, empty6;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: credit and stock as integers; a queue of {vend2,vend6,pulse} per busy cycle.
    int         m_credit;
    int         m_s2, m_s6;
    bit         m_deny, m_rej;
    logic [2:0] q[$];

    vend_ctrl #(.STOCK_INIT(SI), .VEND_CYCLES(VC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin         (coin),
        .sel2         (sel2),
        .sel6         (sel6),
        .cancel       (cancel),
        .restock      (restock),
        .credit       (credit),
        .vend2        (vend2),
        .vend6        (vend6),
        .deny         (deny),
        .coin_rej     (coin_rej),
        .change_pulse (change_pulse),
        .busy         (busy),
        .empty2       (empty2),
        .empty6       (empty6)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_s2     = SI;
        m_s6     = SI;
        m_deny   = 1'b0;
        m_rej    = 1'b0;
        q.delete();
    endtask

    task automatic model_step(input int c, input bit s2, input bit s6, input bit ca, input bit rs);
        bit took;
        took   = 1'b0;
        m_deny = 1'b0;
        m_rej  = 1'b0;
        if (q.size() != 0) begin
            q.delete(0);
            if (c != 0) m_rej = 1'b1;
        end else begin
            if (ca) begin
                if (m_credit > 0) begin
                    for (int k = 0; k < m_credit; k++) begin
                        q.push_back(3'b001);
                        q.push_back(3'b000);
                    end
                    m_credit = 0;
                    took = 1'b1;
                end
            end else if (s6) begin
                if (m_credit >= 6 && m_s6 > 0) begin
                    m_credit -= 6;
                    m_s6--;
                    for (int k = 0; k < VC; k++) q.push_back(3'b010);
                    took = 1'b1;
                end else begin
                    m_deny = 1'b1;
                end
            end else if (s2) begin
                if (m_credit >= 2 && m_s2 > 0) begin
                    m_credit -= 2;
                    m_s2--;
                    for (int k = 0; k < VC; k++) q.push_back(3'b100);
                    took = 1'b1;
                end else begin
                    m_deny = 1'b1;
                end
            end else if (rs) begin
                m_s2 = SI;
                m_s6 = SI;
            end
            if (c != 0) begin
                if (took || (m_credit + c > 255)) m_rej = 1'b1;
                else m_credit += c;
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] e;
        e = (q.size() != 0) ? q[0] : 3'b000;
        check("credit",       credit,       m_credit);
        check("vend2",        vend2,        e[2]);
        check("vend6",        vend6,        e[1]);
        check("change_pulse", change_pulse, e[0]);
        check("busy",         busy,         q.size() != 0);
        check("deny",         deny,         m_deny);
        check("coin_rej",     coin_rej,     m_rej);
        check("empty2",       empty2,       m_s2 == 0);
        check("empty6",       empty6,       m_s6 == 0);
    endtask

    task automatic tick(input int c, input bit s2, input bit s6, input bit ca, input bit rs);
        coin    = 4'(c);
        sel2    = s2;
        sel6    = s6;
        cancel  = ca;
        restock = rs;
        model_step(c, s2, s6, ca, rs);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0;
        coin = 4'd0; sel2 = 1'b0; sel6 = 1'b0; cancel = 1'b0; restock = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_credit", credit, 0);
        check("reset_busy",   busy,   0);
        check("reset_empty2", empty2, 0);
        check("reset_vend6",  vend6,  0);
        rst_n = 1'b1;

        // Two coins of 4 then a 6-priced vend.
        tick(4, 0, 0, 0, 0);
        tick(4, 0, 0, 0, 0);
        check("lit_credit8", credit, 8);
        tick(0, 0, 1, 0, 0);
        check("lit_credit2", credit, 2);
        check("lit_vend6_c1", vend6, 1);
        check("lit_busy_c1", busy, 1);
        idle(1);
        check("lit_vend6_c2", vend6, 1);
        idle(1);
        check("lit_vend6_off", vend6, 0);
        check("lit_busy_off", busy, 0);
        check("lit_empty6_0", empty6, 0);

        // Simultaneous selections: sel6 wins.
        tick(3, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        check("lit_deny5", deny, 1);
        check("lit_credit5", credit, 5);
        check("lit_vend2_5", vend2, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        check("lit_vend6_6", vend6, 1);
        check("lit_credit0", credit, 0);
        idle(VC);

        // Stock depletion with STOCK_INIT=2.
        tick(0, 0, 0, 0, 1);
        tick(6, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check("lit_vend2_a", vend2, 1);
        idle(VC);
        tick(0, 1, 0, 0, 0);
        check("lit_vend2_b", vend2, 1);
        idle(VC);
        tick(0, 1, 0, 0, 0);
        check("lit_deny_empty", deny, 1);
        check("lit_empty2", empty2, 1);
        check("lit_credit_after", credit, 2);
        tick(0, 0, 0, 0, 1);
        check("lit_restock", empty2, 0);

        // Refund 3 units, with a coin arriving during refund.
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        check("lit_cancel_credit", credit, 0);
        pulses = int'(change_pulse);
        for (int i = 0; i < 5; i++) begin
            tick((i == 0) ? 5 : 0, 0, 0, 0, 0);
            pulses += int'(change_pulse);
            if (i == 0) check("lit_coin_rej_change", coin_rej, 1);
        end
        check("lit_pulses3", pulses, 3);
        check("lit_busy_last_low", busy, 1);
        idle(1);
        check("lit_idle_after_change", busy, 0);

        // Overflowing coin is rejected.
        for (int i = 0; i < 16; i++) tick(15, 0, 0, 0, 0);
        tick(10, 0, 0, 0, 0);
        tick(9, 0, 0, 0, 0);
        check("lit_rej_overflow", coin_rej, 1);
        check("lit_credit250", credit, 250);
        tick(0, 0, 0, 1, 0);
        idle(2 * 250 - 1 + 1);
        check("lit_refund250_done", busy, 0);

        // Reset in the middle of a 10-unit refund.
        tick(14, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        idle(VC);
        tick(0, 1, 0, 0, 0);
        idle(VC);
        check("lit_empty2_pre", empty2, 1);
        tick(0, 0, 0, 1, 0);
        check("lit_pulse_pre", change_pulse, 1);
        coin = 4'd0; sel2 = 1'b0; sel6 = 1'b0; cancel = 1'b0; restock = 1'b0;
        rst_n = 1'b0;
        #1;
        check("lit_rst_pulse", change_pulse, 0);
        check("lit_rst_credit", credit, 0);
        check("lit_rst_busy", busy, 0);
        check("lit_rst_empty2", empty2, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("lit_after_rst_busy", busy, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int c;
            c = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 15)) : 0;
            tick(c,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
